// File: rtl/circuit_second_largest.sv
// Running second-largest distinct value of an unsigned sample stream.
// One sample per clock; the result is registered, with no combinational path from input to output.
module circuit_second_largest #(
   parameter int unsigned DATA_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] max1_q, max2_q;
   logic [DATA_WIDTH-1:0] max1_d, max2_d;

   // A repeat of the current maximum is ignored, so max2 stays strictly below max1 once two distinct values are seen.
   always_comb begin
      max1_d = max1_q;
      max2_d = max2_q;
      if (data_in > max1_q) begin
         max2_d = max1_q;
         max1_d = data_in;
      end else if ((data_in < max1_q) && (data_in > max2_q)) begin
         max2_d = data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max1_q <= '0;
         max2_q <= '0;
      end else begin
         max1_q <= max1_d;
         max2_q <= max2_d;
      end
   end

   assign data_out = max2_q;

endmodule

// File: tb/tb_circuit_second_largest.sv
// Bench for circuit_second_largest: expected values are queued when a sample is driven.
// They are popped and compared one time unit after the capturing edge.
module tb_circuit_second_largest;

   localparam int unsigned W = 2;

   logic         clk;
   logic         rst;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;

   int unsigned  n_checks = 0;
   int unsigned  n_fails  = 0;
   logic [W-1:0] exp_q[$];
   bit [(2**W)-1:0] seen;

   circuit_second_largest #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Independent reference: the value 0 is always present (reset state), expected output is
   // the second-highest distinct value in the seen set, or 0 if only one value is present.
   function automatic logic [W-1:0] model_second(input bit [(2**W)-1:0] s);
      int found = 0;
      for (int i = (2**W) - 1; i >= 0; i--) begin
         if (s[i]) begin
            found++;
            if (found == 2) return i[W-1:0];
         end
      end
      return '0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      data_in = '0;
      seen    = '0;
      seen[0] = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [W-1:0] got;
      rst     = 1'b0;
      data_in = '0;
      seen    = '0;
      seen[0] = 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         got = data_out;
         n_checks++;
         if (got !== '0) begin
            n_fails++;
            $display("FAIL reset_hold[%0d]: got=%b exp=%b", i, got, 2'b00);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      got = data_out;
      n_checks++;
      if (got !== '0) begin
         n_fails++;
         $display("FAIL reset_release: got=%b exp=%b", got, 2'b00);
      end
      @(posedge clk);
      #1;
      got = data_out;
      n_checks++;
      if (got !== '0) begin
         n_fails++;
         $display("FAIL reset_first_edge: got=%b exp=%b", got, 2'b00);
      end
   endtask

   // Drives a fixed sequence with spec-given expectations through the scoreboard queue.
   task automatic test_sequence(input string name, input logic [W-1:0] samples[$],
                                input logic [W-1:0] expects[$]);
      logic [W-1:0] got, exp;
      do_reset();
      for (int unsigned i = 0; i < samples.size(); i++) begin
         @(negedge clk);
         data_in = samples[i];
         exp_q.push_back(expects[i]);
         @(posedge clk);
         #1;
         got = data_out;
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL %s[%0d] in=%b: got=%b exp=%b", name, i, samples[i], got, exp);
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic [W-1:0] got, exp;
      logic [W-1:0] s[3] = '{2'b01, 2'b10, 2'b11};
      logic [W-1:0] e[3] = '{2'b00, 2'b01, 2'b10};
      do_reset();
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk);
         data_in = s[i];
         exp_q.push_back(e[i]);
         @(posedge clk);
         #1;
         got = data_out;
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL midreset_pre[%0d]: got=%b exp=%b", i, got, exp);
         end
      end
      #2;
      rst = 1'b0;
      #1;
      got = data_out;
      n_checks++;
      if (got !== '0) begin
         n_fails++;
         $display("FAIL midreset_async: got=%b exp=%b", got, 2'b00);
      end
      @(negedge clk);
      rst     = 1'b1;
      data_in = 2'b10;
      exp_q.push_back(2'b00);
      @(posedge clk);
      #1;
      got = data_out;
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL midreset_after: got=%b exp=%b", got, exp);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] got, exp, d;
      do_reset();
      for (int unsigned i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((i % 60) == 59) begin
            // Occasionally clear history to revisit the low-count cases.
            rst = 1'b0;
            seen    = '0;
            seen[0] = 1'b1;
            #1;
            rst = 1'b1;
         end
         d = W'($urandom_range(0, (2**W) - 1));
         data_in = d;
         seen[d] = 1'b1;
         exp_q.push_back(model_second(seen));
         @(posedge clk);
         #1;
         got = data_out;
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL random[%0d] in=%b: got=%b exp=%b", i, d, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] got, exp;
      // Saturation: max hits all-ones early; only the second value may move afterwards.
      logic [W-1:0] s[6] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
      logic [W-1:0] e[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
      do_reset();
      for (int unsigned i = 0; i < 6; i++) begin
         @(negedge clk);
         data_in = s[i];
         exp_q.push_back(e[i]);
      end
      for (int unsigned i = 0; i < 6; i++) begin
         if (i == 0) @(posedge clk);
      end
      exp_q.delete();
      do_reset();
      for (int unsigned i = 0; i < 6; i++) begin
         @(negedge clk);
         data_in = s[i];
         exp_q.push_back(e[i]);
         @(posedge clk);
         #1;
         got = data_out;
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fails++;
            $display("FAIL saturate[%0d] in=%b: got=%b exp=%b", i, s[i], got, exp);
         end
      end
   endtask

   initial begin
      rst     = 1'b0;
      data_in = '0;
      test_reset();
      test_sequence("seq_a", '{2'b10, 2'b11, 2'b01}, '{2'b00, 2'b10, 2'b10});
      test_sequence("dup_max", '{2'b01, 2'b01, 2'b01}, '{2'b00, 2'b00, 2'b00});
      test_sequence("seq_b", '{2'b11, 2'b10, 2'b11, 2'b01}, '{2'b00, 2'b10, 2'b10, 2'b10});
      test_midstream_reset();
      test_sequence("zero_sample", '{2'b00, 2'b01}, '{2'b00, 2'b00});
      test_back_to_back();
      test_random();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL scoreboard_drain: got=%0d exp=0 leftover entries", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
